// File: rtl/inst_prefetch_cache_pkg.sv
// -----------------------------------------------------------------------------
// inst_prefetch_cache_pkg
// Shared encodings for the instruction prefetch cache and its users:
//   - memory request codes driven on mem_vis_signal (MEM_NOP / MEM_READ / ...)
//   - memory status codes returned on mem_status (MEM_INST_FINISHED marks data)
//   - fetch status codes driven on inst_fetch_status (IF_FINISHED / I_CACHE_*)
//   - FSM state type of the cache controller
// Build option: define I_CACHE_PREFETCH_EN to include the next-line prefetch
// state (ST_PREFETCH_WAIT); without it the FSM has only IDLE and MISS_WAIT.
// -----------------------------------------------------------------------------
package inst_prefetch_cache_pkg;

  // mem_vis_signal: request issued to memory
  localparam logic [1:0] MEM_NOP   = 2'd0;
  localparam logic [1:0] MEM_READ  = 2'd1;
  localparam logic [1:0] MEM_WRITE = 2'd2;

  // mem_status: memory response
  localparam logic [1:0] MEM_RESTING       = 2'd0;
  localparam logic [1:0] MEM_INST_FINISHED = 2'd1;
  localparam logic [1:0] MEM_DATA_FINISHED = 2'd2;
  localparam logic [1:0] MEM_WORKING       = 2'd3;

  // inst_fetch_status: cache response to the fetch stage
  localparam logic [1:0] I_CACHE_RESTING = 2'd0;
  localparam logic [1:0] I_CACHE_WORKING = 2'd1;
  localparam logic [1:0] I_CACHE_STALL   = 2'd2;
  localparam logic [1:0] IF_FINISHED     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE          = 2'd0,
`ifdef I_CACHE_PREFETCH_EN
    ST_MISS_WAIT     = 2'd1,
    ST_PREFETCH_WAIT = 2'd2
`else
    ST_MISS_WAIT     = 2'd1
`endif
  } fsm_state_e;

endpackage

// File: rtl/inst_prefetch_cache_array.sv
// -----------------------------------------------------------------------------
// i_cache_array
// Tag/data/valid storage for the direct-mapped instruction cache.
// Ports:
//   clk      - clock, all state on rising edge
//   clr      - synchronous clear of every valid bit (wins over a write)
//   rd_index - combinational read index
//   rd_valid, rd_tag, rd_data - contents of entry rd_index
//   wr_en, wr_index, wr_tag, wr_data - single write port; sets valid
// -----------------------------------------------------------------------------
module i_cache_array #(
  parameter int TAG_W   = 11,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 4,
  parameter int ENTRIES = 16
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_data
);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  logic [DATA_W-1:0]  data_q [ENTRIES];

  always_comb begin
    valid_d = valid_q;
    if (clr) begin
      valid_d = '0;
    end else if (wr_en) begin
      valid_d[wr_index] = 1'b1;
    end
  end

  // Tag and data need no reset: an entry is only ever read through its valid bit.
  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    if (wr_en && !clr) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/inst_prefetch_cache.sv
// -----------------------------------------------------------------------------
// inst_prefetch_cache
// Direct-mapped instruction cache with optional next-line prefetch.
// Build option: define I_CACHE_PREFETCH_EN to build the next-line prefetch
// (PREFETCH_WAIT state); the default build services misses only.
// Ports:
//   clk, rst           - clock and synchronous active-high reset
//   inst_addr          - fetch byte address (bits [1:0] ignored)
//   inst_fetch_enabled - fetch request, sampled only while idle
//   flush_enabled      - invalidate every entry, abort any memory access
//   instruction        - fetched instruction (registered)
//   inst_fetch_status  - RESTING / WORKING / STALL / IF_FINISHED (registered)
//   mem_data, mem_status     - memory read data (memory byte order) + status
//   mem_vis_addr, mem_vis_signal - word-aligned memory address + request
// Request protocol: the requester holds inst_fetch_enabled and inst_addr
// until it sees IF_FINISHED for one cycle; a request still high in the cycle
// after IF_FINISHED is a new request. Requests are only accepted in IDLE, so
// a request raised during a miss or prefetch is served once IDLE is reached.
// -----------------------------------------------------------------------------
module inst_prefetch_cache
  import inst_prefetch_cache_pkg::*;
#(
  parameter int ADDR_WIDTH         = 17,
  parameter int LEN                = 32,
  parameter int BYTE_SIZE          = 8,
  parameter int I_CACHE_SIZE       = 16,
  parameter int I_CACHE_INDEX_SIZE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  input  logic                  inst_fetch_enabled,
  input  logic                  flush_enabled,
  output logic [LEN-1:0]        instruction,
  output logic [1:0]            inst_fetch_status,
  input  logic [LEN-1:0]        mem_data,
  input  logic [1:0]            mem_status,
  output logic [ADDR_WIDTH-1:0] mem_vis_addr,
  output logic [1:0]            mem_vis_signal
);

  localparam int IDX_W  = I_CACHE_INDEX_SIZE;
  localparam int WORD_W = ADDR_WIDTH - 2;
  localparam int TAG_W  = ADDR_WIDTH - IDX_W - 2;
  localparam int NBYTES = LEN / BYTE_SIZE;

  fsm_state_e            state_q, state_d;
  logic [LEN-1:0]        instruction_q, instruction_d;
  logic [1:0]            status_q, status_d;
  logic [1:0]            mem_sig_q, mem_sig_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

  logic [WORD_W-1:0] fetch_word;
  logic [WORD_W-1:0] lookup_word;
  logic [WORD_W-1:0] mem_word;
  logic              unused_inst_addr_lsbs;
  logic [LEN-1:0]    fill_data;
  logic              mem_done;
  logic              lookup_hit;

  logic [IDX_W-1:0]  rd_index;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [LEN-1:0]    rd_data;
  logic              wr_en;

  assign fetch_word            = inst_addr[ADDR_WIDTH-1:2];
  assign unused_inst_addr_lsbs = ^inst_addr[1:0];
  assign mem_word              = mem_addr_q[ADDR_WIDTH-1:2];
  assign mem_done              = (mem_status == MEM_INST_FINISHED);

`ifdef I_CACHE_PREFETCH_EN
  // Word increment: the next line wraps modulo 2^ADDR_WIDTH by construction.
  logic [WORD_W-1:0] next_word;
  assign next_word = mem_word + 1'b1;
  // The single read port looks up the fetch address while idle and the
  // next line while a miss is outstanding (to decide whether to prefetch).
  assign lookup_word = (state_q == ST_IDLE) ? fetch_word : next_word;
`else
  assign lookup_word = fetch_word;
`endif

  assign rd_index   = lookup_word[IDX_W-1:0];
  assign lookup_hit = rd_valid && (rd_tag == lookup_word[WORD_W-1:IDX_W]);

  // Memory delivers bytes in the opposite order: byte 0 of the stored word
  // is the most significant byte of mem_data.
  for (genvar b = 0; b < NBYTES; b++) begin : g_byte_rev
    assign fill_data[b*BYTE_SIZE +: BYTE_SIZE] =
      mem_data[(NBYTES-1-b)*BYTE_SIZE +: BYTE_SIZE];
  end

  i_cache_array #(
    .TAG_W   (TAG_W),
    .DATA_W  (LEN),
    .INDEX_W (IDX_W),
    .ENTRIES (I_CACHE_SIZE)
  ) u_array (
    .clk      (clk),
    .clr      (rst || flush_enabled),
    .rd_index (rd_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_index (mem_word[IDX_W-1:0]),
    .wr_tag   (mem_word[WORD_W-1:IDX_W]),
    .wr_data  (fill_data)
  );

  always_comb begin
    state_d       = state_q;
    instruction_d = instruction_q;
    status_d      = I_CACHE_RESTING;
    mem_sig_d     = mem_sig_q;
    mem_addr_d    = mem_addr_q;
    wr_en         = 1'b0;

    if (flush_enabled) begin
      // Flush wins over everything, including a fetch in the same cycle.
      state_d   = ST_IDLE;
      mem_sig_d = MEM_NOP;
    end else begin
      case (state_q)
        ST_IDLE: begin
          mem_sig_d = MEM_NOP;
          if (inst_fetch_enabled) begin
            if (lookup_hit) begin
              instruction_d = rd_data;
              status_d      = IF_FINISHED;
            end else begin
              mem_sig_d  = MEM_READ;
              mem_addr_d = {fetch_word, 2'b00};
              status_d   = I_CACHE_WORKING;
              state_d    = ST_MISS_WAIT;
            end
          end
        end

        ST_MISS_WAIT: begin
          if (mem_done) begin
            wr_en         = 1'b1;
            instruction_d = fill_data;
            status_d      = IF_FINISHED;
            state_d       = ST_IDLE;
            mem_sig_d     = MEM_NOP;
`ifdef I_CACHE_PREFETCH_EN
            if (!lookup_hit) begin
              state_d    = ST_PREFETCH_WAIT;
              mem_sig_d  = MEM_READ;
              mem_addr_d = {next_word, 2'b00};
            end
`endif
          end else begin
            status_d = I_CACHE_STALL;
          end
        end

`ifdef I_CACHE_PREFETCH_EN
        ST_PREFETCH_WAIT: begin
          // A completing prefetch is written even if a request arrives in the
          // same cycle; the request is then served from IDLE next cycle.
          if (mem_done) begin
            wr_en     = 1'b1;
            state_d   = ST_IDLE;
            mem_sig_d = MEM_NOP;
          end else if (inst_fetch_enabled) begin
            state_d   = ST_IDLE;
            mem_sig_d = MEM_NOP;
          end
        end
`endif

        default: begin
          state_d   = ST_IDLE;
          mem_sig_d = MEM_NOP;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      instruction_q <= '0;
      status_q      <= I_CACHE_RESTING;
      mem_sig_q     <= MEM_NOP;
      mem_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      instruction_q <= instruction_d;
      status_q      <= status_d;
      mem_sig_q     <= mem_sig_d;
      mem_addr_q    <= mem_addr_d;
    end
  end

  assign instruction       = instruction_q;
  assign inst_fetch_status = status_q;
  assign mem_vis_addr      = mem_addr_q;
  assign mem_vis_signal    = mem_sig_q;

endmodule

// File: tb/tb_inst_prefetch_cache.sv
module tb_inst_prefetch_cache;
  import inst_prefetch_cache_pkg::*;

  localparam int AW = 17;
  localparam int LW = 32;

  typedef struct {
    int         cycles;
    int         reads;
    int         stalls;
    logic       done;
    logic [1:0] first_sig;
    logic [1:0] first_status;
    logic [1:0] end_sig;
    logic [AW-1:0] end_addr;
  } fetch_obs_t;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] inst_addr = '0;
  logic          inst_fetch_enabled = 1'b0;
  logic          flush_enabled = 1'b0;
  logic [LW-1:0] instruction;
  logic [1:0]    inst_fetch_status;
  logic [LW-1:0] mem_data = '0;
  logic [1:0]    mem_status = MEM_RESTING;
  logic [AW-1:0] mem_vis_addr;
  logic [1:0]    mem_vis_signal;

  always #5 clk = ~clk;

  inst_prefetch_cache dut (
    .clk                (clk),
    .rst                (rst),
    .inst_addr          (inst_addr),
    .inst_fetch_enabled (inst_fetch_enabled),
    .flush_enabled      (flush_enabled),
    .instruction        (instruction),
    .inst_fetch_status  (inst_fetch_status),
    .mem_data           (mem_data),
    .mem_status         (mem_status),
    .mem_vis_addr       (mem_vis_addr),
    .mem_vis_signal     (mem_vis_signal)
  );

  int checks = 0;
  int passed = 0;
  logic [LW-1:0] exp_q[$];
  logic [LW-1:0] exp_word;

  // ---------------- memory model ----------------
  int            mem_lat = 0;
  int            mem_cnt = 0;
  logic [AW-1:0] mem_cnt_addr = '0;
  logic          mem_force = 1'b0;
  logic [AW-1:0] force_addr = '0;

  function automatic logic [LW-1:0] mem_word(input logic [AW-1:0] a);
    return 32'h1234_5678 ^ (32'(a) * 32'h9E37_79B1);
  endfunction

  function automatic logic [LW-1:0] rev_bytes(input logic [LW-1:0] w);
    logic [LW-1:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(3-i) +: 8];
    return r;
  endfunction

  // Answers a READ once it has been held on the same address for more than
  // mem_lat cycles.
  always @(negedge clk) begin
    if (mem_force) begin
      mem_status = MEM_INST_FINISHED;
      mem_data   = mem_word(force_addr);
      mem_cnt    = 0;
    end else if (mem_vis_signal == MEM_READ) begin
      if (mem_cnt > 0 && mem_vis_addr == mem_cnt_addr) mem_cnt++;
      else begin
        mem_cnt      = 1;
        mem_cnt_addr = mem_vis_addr;
      end
      if (mem_cnt > mem_lat) begin
        mem_status = MEM_INST_FINISHED;
        mem_data   = mem_word(mem_vis_addr);
      end else begin
        mem_status = MEM_RESTING;
        mem_data   = $urandom;
      end
    end else begin
      mem_cnt    = 0;
      mem_status = MEM_RESTING;
      mem_data   = $urandom;
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && inst_fetch_status == IF_FINISHED) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_finish: got IF_FINISHED instr=%h, required no completion", instruction);
      end else begin
        exp_word = exp_q.pop_front();
        if (instruction !== exp_word)
          $display("FAIL sb_instruction: got %h required %h", instruction, exp_word);
        else passed++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called right after a negedge. Holds the request until IF_FINISHED.
  task automatic run_fetch(input logic [AW-1:0] a, input int lat, output fetch_obs_t o);
    logic [AW-1:0] al;
    al = a & ~AW'(3);
    mem_lat = lat;
    exp_q.push_back(rev_bytes(mem_word(al)));
    inst_addr = a;
    inst_fetch_enabled = 1'b1;
    o.cycles = 0; o.reads = 0; o.stalls = 0; o.done = 1'b0;
    o.first_sig = MEM_NOP; o.first_status = I_CACHE_RESTING;
    while (o.cycles < 60 && !o.done) begin
      @(negedge clk);
      o.cycles++;
      if (o.cycles == 1) begin
        o.first_sig = mem_vis_signal;
        o.first_status = inst_fetch_status;
      end
      if (mem_vis_signal == MEM_READ && mem_vis_addr == al) o.reads++;
      if (inst_fetch_status == I_CACHE_STALL) o.stalls++;
      if (inst_fetch_status == IF_FINISHED) o.done = 1'b1;
    end
    o.end_sig = mem_vis_signal;
    o.end_addr = mem_vis_addr;
    inst_fetch_enabled = 1'b0;
    if (!o.done) void'(exp_q.pop_back());
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (mem_vis_signal != MEM_NOP && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (mem_vis_signal != MEM_NOP)
      $display("FAIL %s_idle_timeout: mem_vis_signal=%0d after %0d cycles, required MEM_NOP", tag, mem_vis_signal, n);
    else passed++;
  endtask

  task automatic do_flush();
    flush_enabled = 1'b1;
    @(negedge clk);
    flush_enabled = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (instruction !== '0) $display("FAIL reset_instr: got %h required 0", instruction); else passed++;
    checks++; if (mem_vis_addr !== '0) $display("FAIL reset_addr: got %h required 0", mem_vis_addr); else passed++;
    checks++; if (mem_vis_signal !== MEM_NOP) $display("FAIL reset_sig: got %0d required %0d", mem_vis_signal, MEM_NOP); else passed++;
    checks++; if (inst_fetch_status !== I_CACHE_RESTING) $display("FAIL reset_status: got %0d required %0d", inst_fetch_status, I_CACHE_RESTING); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_miss_fill();
    fetch_obs_t o;
    run_fetch(17'h00100, 3, o);
    checks++; if (o.done !== 1'b1) $display("FAIL miss_done: got %0d required 1", o.done); else passed++;
    checks++; if (o.first_status !== I_CACHE_WORKING) $display("FAIL miss_first_status: got %0d required %0d", o.first_status, I_CACHE_WORKING); else passed++;
    checks++; if (o.first_sig !== MEM_READ) $display("FAIL miss_first_sig: got %0d required %0d", o.first_sig, MEM_READ); else passed++;
    checks++; if (o.stalls !== 3) $display("FAIL miss_stalls: got %0d required 3", o.stalls); else passed++;
`ifdef I_CACHE_PREFETCH_EN
    checks++; if (o.end_sig !== MEM_READ || o.end_addr !== 17'h00104)
      $display("FAIL miss_prefetch_issue: got sig %0d addr %h required %0d addr 00104", o.end_sig, o.end_addr, MEM_READ); else passed++;
    wait_idle("miss");
    // prefetch address wraps at the top of the address space
    run_fetch(17'h1FFFC, 0, o);
    checks++; if (o.end_sig !== MEM_READ || o.end_addr !== 17'h00000)
      $display("FAIL prefetch_wrap: got sig %0d addr %h required %0d addr 00000", o.end_sig, o.end_addr, MEM_READ); else passed++;
`else
    checks++; if (o.end_sig !== MEM_NOP) $display("FAIL miss_end_sig: got %0d required %0d", o.end_sig, MEM_NOP); else passed++;
`endif
    wait_idle("miss");
  endtask

  task automatic test_hit();
    fetch_obs_t o;
    run_fetch(17'h00100, 3, o);
    checks++; if (o.done !== 1'b1 || o.cycles !== 1) $display("FAIL hit_latency: got done %0d cycles %0d required 1/1", o.done, o.cycles); else passed++;
    checks++; if (o.reads !== 0) $display("FAIL hit_no_read: got %0d reads required 0", o.reads); else passed++;
`ifndef I_CACHE_PREFETCH_EN
    run_fetch(17'h00104, 2, o);
    checks++; if (o.reads == 0) $display("FAIL nopf_next_line_miss: got %0d reads required >0", o.reads); else passed++;
    wait_idle("hit");
`endif
    run_fetch(17'h00104, 3, o);
    checks++; if (o.done !== 1'b1 || o.cycles !== 1) $display("FAIL hit_next_latency: got done %0d cycles %0d required 1/1", o.done, o.cycles); else passed++;
    checks++; if (o.reads !== 0) $display("FAIL hit_next_no_read: got %0d reads required 0", o.reads); else passed++;
    // low address bits are ignored
    run_fetch(17'h00107, 3, o);
    checks++; if (o.cycles !== 1 || o.reads !== 0) $display("FAIL hit_lsb_ignored: got cycles %0d reads %0d required 1/0", o.cycles, o.reads); else passed++;
  endtask

  task automatic test_prefetch_abort();
    fetch_obs_t o;
    do_flush();
    run_fetch(17'h00100, 2, o);
    run_fetch(17'h00200, 2, o);
`ifdef I_CACHE_PREFETCH_EN
    checks++; if (o.first_sig !== MEM_NOP) $display("FAIL abort_nop: got %0d required %0d", o.first_sig, MEM_NOP); else passed++;
    checks++; if (o.first_status !== I_CACHE_RESTING) $display("FAIL abort_status: got %0d required %0d", o.first_status, I_CACHE_RESTING); else passed++;
`else
    checks++; if (o.first_sig !== MEM_READ) $display("FAIL req_after_miss_sig: got %0d required %0d", o.first_sig, MEM_READ); else passed++;
`endif
    checks++; if (o.done !== 1'b1 || o.reads == 0) $display("FAIL abort_miss_200: got done %0d reads %0d required 1/>0", o.done, o.reads); else passed++;
    wait_idle("abort");
    run_fetch(17'h00104, 1, o);
    checks++; if (o.reads == 0) $display("FAIL abort_no_write_104: got %0d reads required >0", o.reads); else passed++;
    wait_idle("abort");
  endtask

  task automatic test_conflict();
    fetch_obs_t o;
    do_flush();
    run_fetch(17'h00100, 1, o);
    checks++; if (o.reads == 0) $display("FAIL conflict_fill: got %0d reads required >0", o.reads); else passed++;
    wait_idle("conflict");
    run_fetch(17'h00140, 1, o);
    checks++; if (o.done !== 1'b1 || o.reads == 0) $display("FAIL conflict_replace: got done %0d reads %0d required 1/>0", o.done, o.reads); else passed++;
    wait_idle("conflict");
    run_fetch(17'h00100, 1, o);
    checks++; if (o.reads == 0) $display("FAIL conflict_evicted: got %0d reads required >0", o.reads); else passed++;
    wait_idle("conflict");
  endtask

  task automatic test_flush();
    fetch_obs_t o;
    int reads;
    run_fetch(17'h00100, 1, o);
    checks++; if (o.cycles !== 1) $display("FAIL flush_pre_hit: got %0d cycles required 1", o.cycles); else passed++;
    inst_addr = 17'h00100;
    inst_fetch_enabled = 1'b1;
    flush_enabled = 1'b1;
    @(negedge clk);
    checks++; if (inst_fetch_status !== I_CACHE_RESTING) $display("FAIL flush_status: got %0d required %0d", inst_fetch_status, I_CACHE_RESTING); else passed++;
    checks++; if (mem_vis_signal !== MEM_NOP) $display("FAIL flush_sig: got %0d required %0d", mem_vis_signal, MEM_NOP); else passed++;
    flush_enabled = 1'b0;
    inst_fetch_enabled = 1'b0;
    reads = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_vis_signal == MEM_READ) reads++;
    end
    checks++; if (reads !== 0) $display("FAIL flush_no_read: got %0d reads required 0", reads); else passed++;
    run_fetch(17'h00100, 1, o);
    checks++; if (o.reads == 0) $display("FAIL flush_invalidated: got %0d reads required >0", o.reads); else passed++;
    wait_idle("flush");
  endtask

  task automatic test_reset_mid_miss();
    fetch_obs_t o;
    do_flush();
    mem_lat = 50;
    inst_addr = 17'h00300;
    inst_fetch_enabled = 1'b1;
    @(negedge clk);
    inst_fetch_enabled = 1'b0;
    checks++; if (mem_vis_signal !== MEM_READ) $display("FAIL rmid_pre_read: got %0d required %0d", mem_vis_signal, MEM_READ); else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (instruction !== '0) $display("FAIL rmid_instr: got %h required 0", instruction); else passed++;
    checks++; if (mem_vis_addr !== '0) $display("FAIL rmid_addr: got %h required 0", mem_vis_addr); else passed++;
    checks++; if (mem_vis_signal !== MEM_NOP) $display("FAIL rmid_sig: got %0d required %0d", mem_vis_signal, MEM_NOP); else passed++;
    checks++; if (inst_fetch_status !== I_CACHE_RESTING) $display("FAIL rmid_status: got %0d required %0d", inst_fetch_status, I_CACHE_RESTING); else passed++;
    rst = 1'b0;
    // late memory completion after the miss was discarded
    @(posedge clk);
    #2 force_addr = 17'h00300;
    mem_force = 1'b1;
    @(posedge clk);
    #2 mem_force = 1'b0;
    @(negedge clk);
    checks++; if (inst_fetch_status !== I_CACHE_RESTING || instruction !== '0)
      $display("FAIL rmid_late_ignored: got status %0d instr %h required %0d/0", inst_fetch_status, instruction, I_CACHE_RESTING); else passed++;
    run_fetch(17'h00300, 1, o);
    checks++; if (o.reads == 0) $display("FAIL rmid_no_write: got %0d reads required >0", o.reads); else passed++;
    wait_idle("rmid");
  endtask

  task automatic test_back_to_back();
    fetch_obs_t o;
    run_fetch(17'h00100, 0, o);
    wait_idle("b2b");
    exp_q.push_back(rev_bytes(mem_word(17'h00100)));
    exp_q.push_back(rev_bytes(mem_word(17'h00100)));
    inst_addr = 17'h00100;
    inst_fetch_enabled = 1'b1;
    @(negedge clk);
    checks++; if (inst_fetch_status !== IF_FINISHED) $display("FAIL b2b_first: got %0d required %0d", inst_fetch_status, IF_FINISHED); else passed++;
    @(negedge clk);
    checks++; if (inst_fetch_status !== IF_FINISHED) $display("FAIL b2b_second: got %0d required %0d", inst_fetch_status, IF_FINISHED); else passed++;
    inst_fetch_enabled = 1'b0;
    @(negedge clk);
    checks++; if (inst_fetch_status !== I_CACHE_RESTING) $display("FAIL b2b_rest: got %0d required %0d", inst_fetch_status, I_CACHE_RESTING); else passed++;
  endtask

  task automatic test_random();
    fetch_obs_t o;
    logic [AW-1:0] a;
    for (int i = 0; i < 24; i++) begin
      a = AW'($urandom_range(0, 255) * 4 + $urandom_range(0, 3));
      run_fetch(a, $urandom_range(0, 4), o);
      checks++; if (o.done !== 1'b1) $display("FAIL rand_timeout: addr %h got no IF_FINISHED in %0d cycles", a, o.cycles); else passed++;
      if ($urandom_range(0, 1) == 1) wait_idle("rand");
    end
    wait_idle("rand");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_miss_fill();
    test_hit();
    test_prefetch_abort();
    test_conflict();
    test_flush();
    test_reset_mid_miss();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d pending expectations required 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/inst_prefetch_cache.md
INST_PREFETCH_CACHE -- requirements
Module: inst_prefetch_cache

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 17, meaning byte-address width.
REQ-002 The module SHALL have parameter LEN, default 32, meaning instruction/word width.
REQ-003 The module SHALL have parameter BYTE_SIZE, default 8, meaning bits per byte for reordering.
REQ-004 The module SHALL have parameter I_CACHE_SIZE, default 16, meaning entry count, a power of two and at least 2.
REQ-005 The module SHALL have parameter I_CACHE_INDEX_SIZE, default 4, equal to log2(I_CACHE_SIZE).
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The module SHALL have port inst_addr, input, ADDR_WIDTH bits: fetch address; bits [1:0] are ignored.
REQ-009 The module SHALL have port inst_fetch_enabled, input, 1 bit: fetch request, sampled only in IDLE.
REQ-010 The module SHALL have port flush_enabled, input, 1 bit: invalidate all entries.
REQ-011 The module SHALL have port instruction, output, LEN bits: the fetched instruction.
REQ-012 The module SHALL have port inst_fetch_status, output, 2 bits: `IF_FINISHED / `I_CACHE_WORKING / `I_CACHE_STALL / `I_CACHE_RESTING.
REQ-013 The module SHALL have port mem_data, input, LEN bits: memory read data in memory byte order.
REQ-014 The module SHALL have port mem_status, input, 2 bits: `MEM_INST_FINISHED marks mem_data valid.
REQ-015 The module SHALL have port mem_vis_addr, output, ADDR_WIDTH bits: word-aligned memory address.
REQ-016 The module SHALL have port mem_vis_signal, output, 2 bits: `MEM_NOP or `MEM_READ.

Function
REQ-017 The cache SHALL be direct-mapped: index = addr[I_CACHE_INDEX_SIZE+1:2], tag = addr[ADDR_WIDTH-1:I_CACHE_INDEX_SIZE+2], with one valid bit per entry.
REQ-018 Fill data SHALL be byte-reversed before storage: {mem_data[7:0], mem_data[15:8], mem_data[23:16], mem_data[31:24]}, generalised over LEN/BYTE_SIZE.
REQ-019 The FSM SHALL have the states IDLE, MISS_WAIT and PREFETCH_WAIT.
REQ-020 IDLE, on inst_fetch_enabled with a hit, SHALL update instruction on the next edge, pulse inst_fetch_status=`IF_FINISHED for one cycle and stay in IDLE (1-cycle latency).
REQ-021 IDLE, on a miss, SHALL drive mem_vis_signal=`MEM_READ and mem_vis_addr=aligned inst_addr on the next edge, set status `I_CACHE_WORKING and go to MISS_WAIT.
REQ-022 In MISS_WAIT, each cycle without `MEM_INST_FINISHED SHALL set status `I_CACHE_STALL and hold address and signal.
REQ-023 In MISS_WAIT, on `MEM_INST_FINISHED, the cache SHALL write tag, data and valid, drive instruction, pulse `IF_FINISHED, then enter PREFETCH_WAIT when prefetch is compiled in and line+4 misses, else IDLE with `MEM_NOP.
REQ-024 PREFETCH_WAIT SHALL read address+4 (wrapping modulo 2^ADDR_WIDTH), fill that entry on `MEM_INST_FINISHED without touching instruction or status, then return to IDLE with `MEM_NOP and status `I_CACHE_RESTING.
REQ-025 inst_fetch_enabled during PREFETCH_WAIT SHALL abort the prefetch: no entry is written, mem_vis_signal=`MEM_NOP next edge, and the request is serviced as an IDLE request on the following cycle.
REQ-026 A prefetch completing on the same cycle as a new request SHALL be written first; the request then sees the updated entry.
REQ-027 flush_enabled SHALL clear all valid bits on the next edge, abort any MISS_WAIT or PREFETCH_WAIT, drive `MEM_NOP and status `I_CACHE_RESTING, and force IDLE; it has priority over a simultaneous fetch, which the requester must re-assert.
REQ-028 inst_fetch_enabled still high in the cycle after `IF_FINISHED SHALL be treated as a new request.

Reset
REQ-029 While rst is high at an edge: all valid bits cleared; FSM to IDLE; instruction=0; mem_vis_addr=0; mem_vis_signal=`MEM_NOP; inst_fetch_status=`I_CACHE_RESTING; any in-flight miss or prefetch is discarded, with no write.

Configuration
REQ-030 Macro I_CACHE_PREFETCH_EN defined: next-line prefetch per REQ-024/025/026 is built.
REQ-031 Macro I_CACHE_PREFETCH_EN undefined: PREFETCH_WAIT and its logic are absent, MISS_WAIT always returns to IDLE, and all other behaviour is unchanged.

Structure
REQ-032 State encodings SHALL live in src/defines.v beside the existing `MEM_* and `IF_*/`I_CACHE_* status codes; this module defines none locally except FSM states.
REQ-033 Tag/data/valid storage SHALL be one sub-module, i_cache_array (read by index, one write port, synchronous clear-all).

Verification
REQ-034 Reset, then fetch 0x00100 (memory returns after 3 stall cycles) -> `I_CACHE_STALL x3, `IF_FINISHED with byte-reversed data, and a prefetch read of 0x00104 issued.
REQ-035 After REQ-034 completes, fetch 0x00104 -> hit, `IF_FINISHED 1 cycle later, no `MEM_READ issued.
REQ-036 Fetch 0x00200 during an outstanding prefetch of 0x00104 -> `MEM_NOP next cycle, then a miss read of 0x00200, and a later fetch of 0x00104 misses.
REQ-037 Fill 0x00100, then fetch 0x00140 (same index, 16 entries) -> miss with replacement, and a re-fetch of 0x00100 misses.
REQ-038 Assert flush and fetch in the same cycle -> `I_CACHE_RESTING, no memory read, and the next fetch of a previously cached address misses.
REQ-039 Assert rst mid-MISS_WAIT -> outputs at reset values next cycle, and a late `MEM_INST_FINISHED is ignored.
